// File: rtl/serial_subtractor_if.sv
// ============================================================================
//  Module      : serial_subtractor_if
//  Description : Start/done handshake and operand/result bus for the
//                bit-serial subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] d;
    logic         bout;
    logic         yprx;
    logic         busy;
    logic         done;

    modport master (
        output start, a, b,
        input  d, bout, yprx, busy, done
    );

    modport slave (
        input  start, a, b,
        output d, bout, yprx, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial two's-complement subtractor, D = A + ~B + 1,
//                LSB first, one bit per clock, start/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int N = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int            CW     = $clog2(N);
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_sa;
    logic [N-1:0]  r_sb;
    logic [N-1:0]  r_r;
    logic          r_cy;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_d;
    logic          r_bout;
    logic          r_yprx;
    logic          r_busy;
    logic          r_done;

    logic          w_nb;
    logic          w_s;
    logic          w_c;
    logic [N-1:0]  w_r_next;
    logic          w_unused;

    // One full-adder slice of A + ~B with the running carry.
    assign w_nb     = ~r_sb[0];
    assign w_s      = r_sa[0] ^ w_nb ^ r_cy;
    assign w_c      = (r_sa[0] & w_nb) | (r_cy & (r_sa[0] ^ w_nb));
    assign w_r_next = {w_s, r_r[N-1:1]};
    // The oldest result bit falls off the register; only its copy in D matters.
    assign w_unused = r_r[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_r     <= '0;
            r_cy    <= 1'b0;
            r_cnt   <= '0;
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_yprx  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_sa    <= bus.a;
                        r_sb    <= bus.b;
                        r_cy    <= 1'b1;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_r   <= w_r_next;
                    r_sa  <= {1'b0, r_sa[N-1:1]};
                    r_sb  <= {1'b0, r_sb[N-1:1]};
                    r_cy  <= w_c;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        r_d     <= w_r_next;
                        r_bout  <= ~w_c;
                        // Carry out of the MSB xor carry into the MSB.
                        r_yprx  <= w_c ^ r_cy;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.d    = r_d;
    assign bus.bout = r_bout;
    assign bus.yprx = r_yprx;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Directed, table-driven self-checking bench for
//                serial_subtractor (N = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;
    localparam int N = 8;

    logic clk;
    logic rst_n;

    serial_subtractor_if #(.N(N)) bus ();

    serial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bout;
        logic       yprx;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation and follow it for N+1 edges after acceptance.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] d, input logic bout, input logic yprx);
        int first_done = 0;
        int done_cnt   = 0;
        int busy_cnt   = 0;
        logic [7:0] d_at_done = '0;
        logic       bo_at_done = 1'b0;
        logic       yp_at_done = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        busy_cnt += int'(bus.busy);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        for (int k = 1; k <= N + 1; k++) begin
            @(posedge clk);
            #1;
            busy_cnt += int'(bus.busy);
            if (bus.done) begin
                done_cnt++;
                if (first_done == 0) begin
                    first_done = k;
                    d_at_done  = bus.d;
                    bo_at_done = bus.bout;
                    yp_at_done = bus.yprx;
                end
            end
        end
        check($sformatf("latency %02h-%02h", a, b), first_done, N);
        check($sformatf("done_pulses %02h-%02h", a, b), done_cnt, 1);
        check($sformatf("busy_cycles %02h-%02h", a, b), busy_cnt, N + 1);
        check($sformatf("d %02h-%02h", a, b), d_at_done, d);
        check($sformatf("bout %02h-%02h", a, b), bo_at_done, bout);
        check($sformatf("yprx %02h-%02h", a, b), yp_at_done, yprx);
        check($sformatf("d_hold %02h-%02h", a, b), bus.d, d);
    endtask

    initial begin
        vecs[0] = '{a: 8'h05, b: 8'h03, d: 8'h02, bout: 1'b0, yprx: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, d: 8'hFE, bout: 1'b1, yprx: 1'b0};
        vecs[2] = '{a: 8'h80, b: 8'h01, d: 8'h7F, bout: 1'b0, yprx: 1'b1};
        vecs[3] = '{a: 8'h7F, b: 8'hFF, d: 8'h80, bout: 1'b1, yprx: 1'b1};
        vecs[4] = '{a: 8'h00, b: 8'h00, d: 8'h00, bout: 1'b0, yprx: 1'b0};
        vecs[5] = '{a: 8'hFF, b: 8'h7F, d: 8'h80, bout: 1'b0, yprx: 1'b0};

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;
        #1;
        check("reset d",    bus.d,    8'h00);
        check("reset bout", bus.bout, 1'b0);
        check("reset yprx", bus.yprx, 1'b0);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bout, vecs[i].yprx);

        // START held high: back-to-back operations, operands changed mid-run.
        // 0xD5-0xAA is -43-(-86) = 43 signed, so no overflow on the first one.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hD5;
        bus.b     = 8'hAA;
        for (int e = 0; e <= 2 * N + 2; e++) begin
            @(posedge clk);
            #1;
            if (e == 3) begin
                bus.a = 8'h55;
                bus.b = 8'hAA;
            end
            if (e >= 1 && e <= N - 1) check($sformatf("held done_low E%0d", e), bus.done, 1'b0);
            if (e == N) begin
                check("held1 done", bus.done, 1'b1);
                check("held1 d",    bus.d,    8'h2B);
                check("held1 bout", bus.bout, 1'b0);
                check("held1 yprx", bus.yprx, 1'b0);
                check("held1 busy", bus.busy, 1'b1);
            end
            if (e == N + 1) begin
                check("held idle busy", bus.busy, 1'b0);
                check("held idle done", bus.done, 1'b0);
            end
            if (e == N + 2) begin
                check("held2 accept busy", bus.busy, 1'b1);
                check("held2 d kept",      bus.d,    8'h2B);
            end
            if (e == 2 * N + 2) begin
                check("held2 done", bus.done, 1'b1);
                check("held2 d",    bus.d,    8'hAB);
                check("held2 bout", bus.bout, 1'b1);
                check("held2 yprx", bus.yprx, 1'b1);
            end
        end
        bus.start = 1'b0;
        repeat (2) @(posedge clk);

        // Asynchronous reset in the middle of bit 4.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'h01;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("pre-abort busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort d",    bus.d,    8'h00);
        check("abort bout", bus.bout, 1'b0);
        check("abort yprx", bus.yprx, 1'b0);
        check("abort busy", bus.busy, 1'b0);
        check("abort done", bus.done, 1'b0);
        begin
            int seen_done = 0;
            for (int k = 0; k < N + 2; k++) begin
                @(posedge clk);
                #1;
                seen_done += int'(bus.done);
            end
            check("abort no done", seen_done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
